// File: rtl/sub_4bit_serial_pkg.sv
// Shared encodings and sizing for the bit-serial subtractor.
// Holds the default operand width, the FSM state encoding and the bit-counter width.
package sub_4bit_serial_pkg;

   localparam int WIDTH_DEF = 4;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      SHIFT = 2'b01,
      DONE  = 2'b10
   } state_t;

   // Kept at least one bit wide so a 1-bit operand still gets a legal counter.
   function automatic int cnt_w(input int w);
      return (w > 1) ? $clog2(w) : 1;
   endfunction

   localparam int CNT_W = cnt_w(WIDTH_DEF);

endpackage

// File: rtl/sub_4bit_serial_full_subtractor.sv
// One-bit borrow cell: diff = x - y - bin, bout set when that goes negative.
// Purely combinational, zero latency, no flow control.
module full_subtractor (
   input  logic x,
   input  logic y,
   input  logic bin,
   output logic diff,
   output logic bout
);

   assign diff = x ^ y ^ bin;
   assign bout = (~x & y) | (~(x ^ y) & bin);

endmodule

// File: rtl/sub_4bit_serial.sv
// Bit-serial unsigned subtractor, LSB first, d = {a<b, (a-b) mod 2^WIDTH}.
// Latency WIDTH cycles from accepting edge to done; start is only sampled in IDLE.
module sub_4bit_serial
   import sub_4bit_serial_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH:0]   d
);

   localparam int            CW   = cnt_w(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   state_t           state;
   state_t           state_nxt;
   logic [WIDTH-1:0] a_sr;
   logic [WIDTH-1:0] b_sr;
   logic [WIDTH-1:0] res;
   logic             bor;
   logic [CW-1:0]    cnt;
   logic             diff_bit;
   logic             bor_nxt;
   logic             last_bit;

   full_subtractor u_fs (
      .x    (a_sr[0]),
      .y    (b_sr[0]),
      .bin  (bor),
      .diff (diff_bit),
      .bout (bor_nxt)
   );

   assign last_bit = (cnt == LAST);

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = SHIFT;
         SHIFT:   if (last_bit) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // busy/done come from the next state so both are plain flops aligned with state.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
         busy  <= 1'b0;
         done  <= 1'b0;
      end else begin
         state <= state_nxt;
         busy  <= (state_nxt == SHIFT);
         done  <= (state_nxt == DONE);
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         a_sr <= '0;
         b_sr <= '0;
         res  <= '0;
         bor  <= 1'b0;
         cnt  <= '0;
         d    <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  a_sr <= a;
                  b_sr <= b;
                  bor  <= 1'b0;
                  cnt  <= '0;
               end
            end
            SHIFT: begin
               a_sr <= a_sr >> 1;
               b_sr <= b_sr >> 1;
               res  <= {diff_bit, res[WIDTH-1:1]};
               bor  <= bor_nxt;
               cnt  <= cnt + 1'b1;
               // Final bit goes straight into d; res would only hold it one edge later.
               if (last_bit) d <= {bor_nxt, diff_bit, res[WIDTH-1:1]};
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_sub_4bit_serial.sv
// Directed and exhaustive checks of sub_4bit_serial with a result scoreboard.
module tb_sub_4bit_serial;

   logic       clock;
   logic       reset_n;
   logic       start;
   logic [3:0] a;
   logic [3:0] b;
   logic       busy;
   logic       done;
   logic [4:0] d;

   int         total = 0;
   int         bad   = 0;
   int         cyc   = 0;
   logic [4:0] sb[$];
   int         done_times[$];
   logic       done_prev = 1'b0;

   sub_4bit_serial #(.WIDTH(4)) dut (
      .clock   (clock),
      .reset_n (reset_n),
      .start   (start),
      .a       (a),
      .b       (b),
      .busy    (busy),
      .done    (done),
      .d       (d)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   always @(posedge clock) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [4:0] model(input logic [3:0] x, input logic [3:0] y);
      logic [3:0] dif;
      dif = x - y;
      return {x < y, dif};
   endfunction

   // Scoreboard side: every done pulse must match the oldest pushed expectation.
   always @(negedge clock) begin
      if (reset_n && done) begin
         chk("done_width", done_prev, 0);
         chk("sb_nonempty", sb.size() != 0, 1);
         if (sb.size() != 0) chk("d", d, sb.pop_front());
         done_times.push_back(cyc);
      end
      done_prev = done;
   end

   task automatic run_op(input logic [3:0] ta, input logic [3:0] tb_v, input logic [4:0] exp);
      int n;
      @(negedge clock);
      a = ta;
      b = tb_v;
      start = 1'b1;
      sb.push_back(exp);
      @(posedge clock);
      #1;
      start = 1'b0;
      a = 4'($urandom);
      b = 4'($urandom);
      chk("busy_after_accept", busy, 1);
      n = 0;
      while (!done && n < 20) begin
         @(posedge clock);
         #1;
         n++;
         if (!done && n < 4) chk("busy_in_shift", busy, 1);
      end
      chk("latency", n, 4);
      chk("busy_at_done", busy, 0);
      @(posedge clock);
      #1;
      chk("done_cleared", done, 0);
      chk("d_hold", d, exp);
   endtask

   initial begin
      int n0;
      reset_n = 1'b0;
      start   = 1'b0;
      a       = 4'h0;
      b       = 4'h0;
      repeat (2) @(posedge clock);
      #1;
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_d", d, 0);
      @(negedge clock);
      reset_n = 1'b1;
      repeat (3) @(posedge clock);
      #1;
      chk("idle_no_start", busy, 0);

      run_op(4'h5, 4'h3, 5'h02);
      run_op(4'h3, 4'h5, 5'h1E);
      run_op(4'h0, 4'h1, 5'h1F);
      run_op(4'hF, 4'hF, 5'h00);
      run_op(4'h8, 4'hD, 5'h1B);

      // Held start: three operations, operands scrambled while busy.
      n0 = done_times.size();
      @(negedge clock);
      a = 4'hD;
      b = 4'h5;
      start = 1'b1;
      repeat (3) sb.push_back(5'h08);
      repeat (17) begin
         @(negedge clock);
         if (busy) begin
            a = 4'($urandom);
            b = 4'($urandom);
         end else begin
            a = 4'hD;
            b = 4'h5;
         end
      end
      @(negedge clock);
      start = 1'b0;
      repeat (3) @(posedge clock);
      #1;
      chk("held_done_count", done_times.size() - n0, 3);
      if (done_times.size() - n0 == 3) begin
         chk("held_spacing_1", done_times[n0+1] - done_times[n0], 6);
         chk("held_spacing_2", done_times[n0+2] - done_times[n0+1], 6);
      end

      // Reset in the second SHIFT cycle aborts without a done pulse.
      @(negedge clock);
      a = 4'h7;
      b = 4'h2;
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      @(posedge clock);
      #2;
      chk("pre_reset_busy", busy, 1);
      reset_n = 1'b0;
      #1;
      chk("abort_busy", busy, 0);
      chk("abort_done", done, 0);
      chk("abort_d", d, 0);
      @(negedge clock);
      reset_n = 1'b1;
      repeat (6) @(posedge clock);
      #1;
      chk("abort_no_done", done, 0);
      run_op(4'h9, 4'h4, 5'h05);

      for (int i = 0; i < 256; i++) begin
         logic [3:0] x;
         logic [3:0] y;
         x = 4'(i >> 4);
         y = 4'(i);
         run_op(x, y, model(x, y));
      end

      chk("sb_drained", sb.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
